c_packet_channel_alloc: RTL

Wormhole output-channel allocator: shares one downstream channel between `num_ports` input requesters using matrix-priority (least-recently-served) arbitration at packet granularity, holds the grant for the winning input from head flit to tail flit, and gates every flit grant on a downstream credit counter. It sits in front of a router output port, between the input VC/port request logic and the crossbar select.

---
 rtl/c_packet_channel_alloc_pkg.sv | 19 +
 rtl/c_credit_counter.sv | 37 +++
 rtl/c_packet_channel_alloc.sv | 127 ++++++++++++
 3 files changed

// File: rtl/c_packet_channel_alloc_pkg.sv
// Shared types and sizing helpers for the wormhole output-channel allocator.
package c_packet_channel_alloc_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_t;

    function automatic int unsigned credit_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Flat index of upper-triangle matrix cell (i,j), i<j, for an n x n matrix.
    function automatic int unsigned tri_idx(input int unsigned n, input int unsigned i,
                                            input int unsigned j);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/c_credit_counter.sv
// Downstream credit counter: saturating at num_credits, flags a return into a full counter.
module c_credit_counter
    import c_packet_channel_alloc_pkg::*;
#(
    parameter  int unsigned num_credits = 4,
    localparam int unsigned cw          = credit_width(num_credits)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec,
    input  logic          inc,
    output logic [cw-1:0] count,
    output logic          nonzero,
    output logic          overflow
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= cw'(num_credits);
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (dec && !inc) begin
                count <= count - cw'(1);
            end else if (inc && !dec) begin
                if (count == cw'(num_credits)) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + cw'(1);
                end
            end
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/c_packet_channel_alloc.sv
// Wormhole output-channel allocator: least-recently-served matrix arbitration per packet,
// grant held head-to-tail, every flit gated on downstream credits.
module c_packet_channel_alloc
    import c_packet_channel_alloc_pkg::*;
#(
    parameter  int unsigned num_ports   = 8,
    parameter  int unsigned num_credits = 4,
    localparam int unsigned cw          = credit_width(num_credits)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:num_ports-1] req,
    input  logic [0:num_ports-1] head,
    input  logic [0:num_ports-1] tail,
    input  logic                 credit_return,
    output logic [0:num_ports-1] gnt,
    output logic                 gnt_valid,
    output logic                 locked,
    output logic [cw-1:0]        credits,
    output logic                 err_proto,
    output logic                 err_credit
);

    localparam int unsigned tri_w  = num_ports * (num_ports - 1) / 2;
    localparam int unsigned tri_iw = (tri_w > 1) ? $clog2(tri_w) : 1;

    alloc_state_t         state_q, state_d;
    logic [0:num_ports-1] owner_q, owner_d;
    logic [tri_w-1:0]     pri_q, pri_d;
    logic [0:num_ports-1] cand, win;
    logic                 nonzero;
    logic                 done;

    // Row i beats column j; only the upper triangle is stored.
    function automatic logic beats(input logic [tri_w-1:0] m, input int unsigned i,
                                   input int unsigned j);
        if (i == j) return 1'b1;
        if (i < j) return m[tri_iw'(tri_idx(num_ports, i, j))];
        return ~m[tri_iw'(tri_idx(num_ports, j, i))];
    endfunction

    // Head-flit candidate that beats every other candidate.
    always_comb begin
        cand = req & head;
        win  = '0;
        for (int unsigned w = 0; w < num_ports; w++) begin
            win[w] = cand[w];
            for (int unsigned j = 0; j < num_ports; j++) begin
                if (j != w && cand[j] && !beats(pri_q, w, j)) win[w] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gnt       = '0;
        err_proto = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (nonzero && |win) begin
                    gnt = win;
                    if (|(win & tail)) begin
                        done = 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = win;
                    end
                end
            end
            ST_LOCKED: begin
                if (|(owner_q & req & head)) begin
                    err_proto = 1'b1;
                end else if (nonzero && |(owner_q & req)) begin
                    gnt = owner_q;
                    if (|(owner_q & tail)) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet winner drops to lowest priority against everyone else.
    always_comb begin
        pri_d = pri_q;
        if (done) begin
            for (int unsigned i = 0; i < num_ports; i++) begin
                for (int unsigned j = i + 1; j < num_ports; j++) begin
                    if (gnt[i]) pri_d[tri_iw'(tri_idx(num_ports, i, j))] = 1'b0;
                    else if (gnt[j]) pri_d[tri_iw'(tri_idx(num_ports, i, j))] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            pri_q   <= '1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pri_q   <= pri_d;
        end
    end

    assign gnt_valid = |gnt;
    assign locked    = (state_q == ST_LOCKED);

    c_credit_counter #(
        .num_credits (num_credits)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .dec      (gnt_valid),
        .inc      (credit_return),
        .count    (credits),
        .nonzero  (nonzero),
        .overflow (err_credit)
    );

endmodule
